// File: rtl/led_scan_driver.sv
// led_scan_driver: double-buffered row-scan engine for an 8x8 bicolour LED matrix fed from frame RAM
module led_scan_driver #(
  parameter int DWELL_CYC      = 1000,
  parameter int BLANK_CYC      = 4,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rd_en,
  input  logic       rd_grant,
  output logic [7:0] addr_row,
  output logic [7:0] addr_col,
  input  logic [3:0] rd_data,
  output logic [7:0] row_sel,
  output logic [7:0] col_r,
  output logic [7:0] col_g,
  output logic [2:0] cur_row,
  output logic       frame_done
);
  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLANK_CYC - 1);
  localparam logic [7:0] ROFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] COFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, PRIME, BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic          rd_en_q, rd_en_d, cap_q, cap_d, fdone_q, fdone_d, fd_q, fd_d;
  logic [2:0]    arow_q, arow_d, acol_q, acol_d, ccol_q, ccol_d, cur_q, cur_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [7:0]    rs_q, rs_d, cr_q, cr_d, cg_q, cg_d;
  logic [7:0]    sr_q, sg_q;
  logic          acc, last_acc, fdone_now;
  logic          unused;

  assign unused    = rd_data[0];
  assign acc       = rd_en_q & rd_grant;
  assign last_acc  = acc & (acol_q == 3'd7);
  assign fdone_now = fdone_q | (cap_q & (ccol_q == 3'd7));

  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    arow_d  = arow_q;
    acol_d  = acol_q;
    cap_d   = 1'b0;
    ccol_d  = ccol_q;
    fdone_d = fdone_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    cur_d   = cur_q;
    rs_d    = rs_q;
    cr_d    = cr_q;
    cg_d    = cg_q;
    fd_d    = 1'b0;
    if (state_q == PRIME || state_q == SHOW) begin
      cap_d   = acc;
      ccol_d  = acol_q;
      acol_d  = (acc && !last_acc) ? acol_q + 3'd1 : acol_q;
      rd_en_d = rd_en_q & ~last_acc;
      fdone_d = fdone_now;
    end
    case (state_q)
      IDLE: if (en) begin
        state_d = PRIME;
        rd_en_d = 1'b1;
        acol_d  = 3'd0;
        arow_d  = 3'd0;
        fdone_d = 1'b0;
      end
      PRIME: if (fdone_now) begin
        state_d = BLANK;
        bcnt_d  = '0;
      end
      BLANK: begin
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BLAST) begin
          state_d = SHOW;
          cur_d   = arow_q;
          rs_d    = (8'd1 << arow_q) ^ ROFF;
          cr_d    = sr_q ^ COFF;
          cg_d    = sg_q ^ COFF;
          rd_en_d = 1'b1;
          acol_d  = 3'd0;
          arow_d  = arow_q + 3'd1;
          fdone_d = 1'b0;
          dcnt_d  = '0;
        end
      end
      SHOW: begin
        dcnt_d = (dcnt_q == DLAST) ? dcnt_q : dcnt_q + DW'(1);
        if (dcnt_q == DLAST && fdone_now) begin
          state_d = BLANK;
          bcnt_d  = '0;
          rs_d    = ROFF;
          cr_d    = COFF;
          cg_d    = COFF;
        end
      end
      default: state_d = IDLE;
    endcase
    // registered pulse: predict that the coming cycle is the last SHOW cycle of row 7
    fd_d = (state_d == SHOW) && (cur_d == 3'd7) && (dcnt_d == DLAST) &&
           (fdone_d | (cap_d & (ccol_d == 3'd7)));
    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      rd_en_d = 1'b0;
      cap_d   = 1'b0;
      acol_d  = 3'd0;
      arow_d  = 3'd0;
      fdone_d = 1'b0;
      cur_d   = 3'd0;
      rs_d    = ROFF;
      cr_d    = COFF;
      cg_d    = COFF;
      fd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      arow_q  <= 3'd0;
      acol_q  <= 3'd0;
      cap_q   <= 1'b0;
      ccol_q  <= 3'd0;
      fdone_q <= 1'b0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      cur_q   <= 3'd0;
      rs_q    <= ROFF;
      cr_q    <= COFF;
      cg_q    <= COFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      arow_q  <= arow_d;
      acol_q  <= acol_d;
      cap_q   <= cap_d;
      ccol_q  <= ccol_d;
      fdone_q <= fdone_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      cur_q   <= cur_d;
      rs_q    <= rs_d;
      cr_q    <= cr_d;
      cg_q    <= cg_d;
      fd_q    <= fd_d;
    end
  end

  // shadow keeps only the lit colour bits; a datum in flight when en drops is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= 8'h00;
      sg_q <= 8'h00;
    end else if (cap_q && en) begin
      sr_q[ccol_q] <= rd_data[1] & rd_data[3];
      sg_q[ccol_q] <= rd_data[2] & rd_data[3];
    end
  end

  assign rd_en      = rd_en_q;
  assign addr_row   = {5'd0, arow_q};
  assign addr_col   = {5'd0, acol_q};
  assign row_sel    = rs_q;
  assign col_r      = cr_q;
  assign col_g      = cg_q;
  assign cur_row    = cur_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: directed table-driven bench for led_scan_driver (DWELL=16, BLANK=2, both polarities)
module tb_led_scan_driver;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, rd_grant = 1'b1;
  logic [3:0] rd_data = 4'd0;
  logic       rd_en, frame_done, rd_en_n, frame_done_n;
  logic [7:0] addr_row, addr_col, row_sel, col_r, col_g;
  logic [7:0] addr_row_n, addr_col_n, row_sel_n, col_r_n, col_g_n;
  logic [2:0] cur_row, cur_row_n;

  typedef struct {
    logic [2:0] col;
    logic [3:0] px;
    logic [7:0] er;
    logic [7:0] eg;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] ram[8][8];
  int         ncmp = 0, nbad = 0;
  logic [7:0] rs, er, eg;
  logic [2:0] ar, ac, cr;
  logic       re, fd;
  logic [23:0] inv;

  led_scan_driver #(.DWELL_CYC(16), .BLANK_CYC(2), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .rd_grant(rd_grant),
    .addr_row(addr_row), .addr_col(addr_col), .rd_data(rd_data),
    .row_sel(row_sel), .col_r(col_r), .col_g(col_g), .cur_row(cur_row), .frame_done(frame_done));

  led_scan_driver #(.DWELL_CYC(16), .BLANK_CYC(2), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en_n), .rd_grant(rd_grant),
    .addr_row(addr_row_n), .addr_col(addr_col_n), .rd_data(rd_data),
    .row_sel(row_sel_n), .col_r(col_r_n), .col_g(col_g_n), .cur_row(cur_row_n), .frame_done(frame_done_n));

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en && rd_grant) rd_data <= ram[addr_row[2:0]][addr_col[2:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s @%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart;
    rst = 1'b1;
    en = 1'b0;
    rd_grant = 1'b1;
    adv(2);
    rst = 1'b0;
    adv(1);
    en = 1'b1;
  endtask

  initial begin
    tbl[0] = '{3'd0, 4'b1110, 8'h01, 8'h01};
    tbl[1] = '{3'd5, 4'b0110, 8'h00, 8'h00};
    tbl[2] = '{3'd5, 4'b1100, 8'h00, 8'h20};
    tbl[3] = '{3'd7, 4'b1010, 8'h80, 8'h00};
    tbl[4] = '{3'd2, 4'b1111, 8'h04, 8'h04};
    tbl[5] = '{3'd3, 4'b1000, 8'h00, 8'h00};
    tbl[6] = '{3'd6, 4'b0001, 8'h00, 8'h00};
    tbl[7] = '{3'd1, 4'b1110, 8'h02, 8'h02};
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ram[r][c] = 4'd0;
    for (int r = 0; r < 8; r++) ram[r][tbl[r].col] = tbl[r].px;

    adv(2);
    chk("reset", {row_sel, col_r, col_g, addr_row, addr_col, rd_en, frame_done, cur_row}, 64'd0);
    chk("reset_inv", {row_sel_n, col_r_n, col_g_n}, {24'hFFFFFF});

    // full frame plus wrap, with a per-cycle expectation from the table
    restart;
    for (int t = 1; t <= 160; t++) begin
      adv(1);
      rs = 8'h00; er = 8'h00; eg = 8'h00; re = 1'b0; fd = 1'b0; ar = 3'd0; ac = 3'd0; cr = 3'd0;
      if (t <= 9) begin
        re = (t <= 8);
        ac = 3'(t - 1);
      end else if (t >= 12) begin
        int k, r;
        k = (t - 12) % 18;
        r = ((t - 12) / 18) % 8;
        cr = 3'(r);
        ar = 3'((r + 1) % 8);
        ac = 3'(k);
        re = (k <= 7);
        fd = (k == 15) && (r == 7);
        if (k < 16) begin
          rs = 8'd1 << r;
          er = tbl[r].er;
          eg = tbl[r].eg;
        end
      end
      chk("frame", {row_sel, col_r, col_g, rd_en, frame_done, cur_row}, {rs, er, eg, re, fd, cr});
      if (re) chk("fetch_addr", {addr_row, addr_col}, {5'd0, ar, 5'd0, ac});
      inv = ~{rs, er, eg};
      chk("frame_inv", {row_sel_n, col_r_n, col_g_n}, {40'd0, inv});
    end

    // asynchronous reset mid-SHOW of row 0
    #2 rst = 1'b1;
    #1 chk("async_rst", {row_sel, col_r, col_g, rd_en, cur_row}, 64'd0);
    chk("async_rst_inv", {row_sel_n, col_r_n, col_g_n}, {24'hFFFFFF});
    en = 1'b0;
    adv(1);
    rst = 1'b0;
    adv(3);
    chk("idle_hold", {rd_en, row_sel}, 64'd0);
    en = 1'b1;
    adv(1);
    chk("idle_resume", {rd_en, addr_row, addr_col}, {1'b1, 16'd0});

    // grant withheld for 30 cycles during SHOW of row 3
    restart;
    adv(68);
    rd_grant = 1'b0;
    for (int t = 68; t < 98; t++) begin
      chk("stall", {rd_en, addr_col, row_sel}, {1'b1, 8'd2, 8'h08});
      adv(1);
    end
    rd_grant = 1'b1;
    adv(6);
    chk("stall_extend", {row_sel, rd_en}, {8'h08, 1'b0});
    adv(1);
    chk("stall_blank", row_sel, 64'h00);
    adv(2);
    chk("stall_row4", {row_sel, col_r, col_g, cur_row}, {8'h10, tbl[4].er, tbl[4].eg, 3'd4});

    // en dropped during PRIME column 4
    restart;
    adv(5);
    chk("prime_col4", {rd_en, addr_col}, {1'b1, 8'd4});
    en = 1'b0;
    adv(1);
    chk("en_drop", {rd_en, row_sel, col_r, col_g, addr_col}, 64'd0);
    chk("en_drop_inv", row_sel_n, 64'hFF);
    en = 1'b1;
    adv(1);
    chk("reprime", {rd_en, addr_col, addr_row}, {1'b1, 16'd0});
    adv(10);
    chk("reprime_blank", row_sel, 64'h00);
    adv(1);
    chk("reprime_row0", {row_sel, col_r, col_g, cur_row}, {8'h01, tbl[0].er, tbl[0].eg, 3'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
